// File: rtl/difftest_step_batcher.sv
// difftest_step_batcher: gathers per-cycle commit counts into batches, hands
// each batch to the software checker over a request/response handshake,
// latches the checker verdict and throttles the DUT when too much is pending.
module difftest_step_batcher #(
  parameter int unsigned STEP_W    = 8,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned BATCH_MAX = 64,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [STEP_W-1:0] step_in,
  input  logic              flush,
  output logic              req_valid,
  output logic [CNT_W-1:0]  req_count,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [7:0]        rsp_result,
  output logic [7:0]        simv_result,
  output logic              dut_stall,
  output logic              busy,
  output logic [CNT_W-1:0]  batch_count
);

  typedef enum logic [1:0] {ACCUM, REQ, WAIT, HALT} state_t;

  localparam logic [CNT_W-1:0] BATCH_LIM = CNT_W'(BATCH_MAX);
  localparam logic [CNT_W-1:0] TIMER_LIM = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       VERDICT_FAIL = 8'h2;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] timer;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] acc_next;
  logic             overflow;
  logic             issue;

  // Accumulator sum, overflow detection and batch issue decision
  always_comb begin
    sum      = {1'b0, acc} + (CNT_W + 1)'(step_in);
    acc_next = sum[CNT_W-1:0];
    overflow = sum[CNT_W] && (state != HALT);
    // Overflow outranks issue: a wrapped count must never be offered.
    issue    = (state == ACCUM) && !sum[CNT_W] &&
               ((acc_next >= BATCH_LIM) ||
                ((acc != '0) && (timer >= TIMER_LIM)) ||
                (flush && (acc_next != '0)));
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ACCUM;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ACCUM: begin
        if (overflow)   state_next = HALT;
        else if (issue) state_next = REQ;
      end
      REQ: begin
        if (overflow)       state_next = HALT;
        else if (req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (overflow)       state_next = HALT;
        else if (rsp_valid) state_next = (rsp_result == 8'h0) ? ACCUM : HALT;
      end
      default: state_next = HALT;
    endcase
  end

  // Datapath registers: accumulator, timer, offered count, verdict, batch tally
  always_ff @(posedge clock) begin
    if (reset) begin
      acc         <= '0;
      timer       <= '0;
      req_count   <= '0;
      simv_result <= '0;
      batch_count <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (overflow) begin
            simv_result <= VERDICT_FAIL;
          end else if (issue) begin
            req_count <= acc_next;
            acc       <= '0;
            timer     <= '0;
          end else begin
            acc   <= acc_next;
            timer <= (acc != '0) ? timer + CNT_W'(1) : '0;
          end
        end
        REQ, WAIT: begin
          if (overflow) begin
            simv_result <= VERDICT_FAIL;
          end else begin
            acc <= acc_next;
            if ((state == WAIT) && rsp_valid) begin
              if (rsp_result == 8'h0) batch_count <= batch_count + CNT_W'(1);
              else                    simv_result <= rsp_result;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and accumulator level
  always_comb begin
    req_valid = 1'b0;
    busy      = 1'b0;
    dut_stall = 1'b0;
    req_valid = (state == REQ);
    busy      = (state == REQ) || (state == WAIT);
    dut_stall = (state == HALT) || (acc >= BATCH_LIM);
  end

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Bench for difftest_step_batcher: a behavioural model predicts each batch
// and per-cycle outputs; a monitor matches offered batches against a queue.
module tb_difftest_step_batcher;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [7:0]  step_in;
  logic        flush, req_ready, rsp_valid;
  logic [7:0]  rsp_result;
  logic        req_valid, dut_stall, busy;
  logic [31:0] req_count, batch_count;
  logic [7:0]  simv_result;

  difftest_step_batcher #(.STEP_W(8), .CNT_W(32), .BATCH_MAX(64), .TIMEOUT(16)) u_dut (
    .clock(clock), .reset(reset), .step_in(step_in), .flush(flush),
    .req_valid(req_valid), .req_count(req_count), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .simv_result(simv_result),
    .dut_stall(dut_stall), .busy(busy), .batch_count(batch_count)
  );

  // Narrow instance used only to reach accumulator overflow
  logic       s_reset;
  logic [7:0] s_step;
  logic       s_req_valid, s_stall, s_busy;
  logic [7:0] s_req_count, s_simv, s_batch;

  difftest_step_batcher #(.STEP_W(8), .CNT_W(8), .BATCH_MAX(64), .TIMEOUT(16)) u_small (
    .clock(clock), .reset(s_reset), .step_in(s_step), .flush(1'b0),
    .req_valid(s_req_valid), .req_count(s_req_count), .req_ready(1'b0),
    .rsp_valid(1'b0), .rsp_result(8'h0), .simv_result(s_simv),
    .dut_stall(s_stall), .busy(s_busy), .batch_count(s_batch)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: outstanding/taken/halted flags and plain integers
  localparam longint LIMIT = 64;
  localparam longint TO    = 16;
  localparam longint WRAP  = 64'h1_0000_0000;

  longint m_acc = 0, m_timer = 0, m_batches = 0;
  int     m_simv = 0;
  bit     m_out = 0, m_taken = 0, m_halt = 0;
  longint exp_q[$];

  initial forever begin
    longint sum;
    bit     fire;
    @(posedge clock);
    if (reset) begin
      m_acc = 0; m_timer = 0; m_batches = 0; m_simv = 0;
      m_out = 0; m_taken = 0; m_halt = 0;
      exp_q.delete();
    end else if (!m_halt) begin
      sum = m_acc + longint'(step_in);
      if (sum >= WRAP) begin
        m_halt = 1; m_simv = 2;
      end else if (!m_out) begin
        fire = (sum >= LIMIT) || (m_acc != 0 && m_timer >= TO - 1) || (flush && sum != 0);
        if (fire) begin
          exp_q.push_back(sum);
          m_acc = 0; m_timer = 0; m_out = 1; m_taken = 0;
        end else begin
          m_timer = (m_acc != 0) ? m_timer + 1 : 0;
          m_acc   = sum;
        end
      end else begin
        m_acc = sum;
        if (!m_taken) begin
          if (req_ready) m_taken = 1;
        end else if (rsp_valid) begin
          if (rsp_result == 8'h0) begin m_batches++; m_out = 0; end
          else begin m_simv = int'(rsp_result); m_halt = 1; end
        end
      end
    end
  end

  // Monitor: per-cycle outputs against the model, offered batches against the queue
  bit     mon_en = 0;
  bit     in_req = 0;
  longint held = 0;

  initial forever begin
    @(negedge clock);
    if (mon_en) begin
      check("req_valid", req_valid, (m_out && !m_taken && !m_halt) ? 1 : 0);
      check("busy", busy, (m_out && !m_halt) ? 1 : 0);
      check("dut_stall", dut_stall, (m_halt || m_acc >= LIMIT) ? 1 : 0);
      check("simv_result", simv_result, m_simv);
      check("batch_count", batch_count, m_batches);
      if (req_valid) begin
        if (!in_req) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL req_count: got request of %0d expected none", req_count);
          end else begin
            held = exp_q.pop_front();
            check("req_count", req_count, held);
          end
          in_req = 1;
        end else begin
          check("req_count_hold", req_count, held);
        end
        if (req_ready) in_req = 0;
      end else begin
        in_req = 0;
      end
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [7:0] st, input logic fl, input logic rdy,
                       input logic rv, input logic [7:0] rr);
    step_in = st; flush = fl; req_ready = rdy; rsp_valid = rv; rsp_result = rr;
    cycle();
  endtask

  initial begin
    int k;
    bit seen;
    reset = 1'b1; step_in = '0; flush = 1'b0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_result = '0;
    s_reset = 1'b1; s_step = '0;
    cycle(); cycle();
    reset = 1'b0;
    mon_en = 1;
    check("rst_req_valid", req_valid, 0);
    check("rst_simv", simv_result, 0);
    check("rst_batch", batch_count, 0);
    check("rst_stall", dut_stall, 0);

    // Threshold: eight steps of 8 make one batch of 64
    for (int i = 0; i < 8; i++) drive(8'd8, 1'b0, 1'b1, 1'b0, 8'h0);
    check("thresh_valid", req_valid, 1);
    check("thresh_count", req_count, 64);
    drive(8'd0, 1'b0, 1'b1, 1'b0, 8'h0);
    drive(8'd0, 1'b0, 1'b0, 1'b0, 8'h0);
    drive(8'd0, 1'b0, 1'b0, 1'b1, 8'h0);
    check("thresh_batches", batch_count, 1);

    // Timeout: a lone step of 3 is issued TIMEOUT cycles after it is held
    drive(8'd3, 1'b0, 1'b0, 1'b0, 8'h0);
    k = 0; seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      drive(8'd0, 1'b0, 1'b0, 1'b0, 8'h0);
      if (req_valid) begin seen = 1; k = i; end
    end
    check("timeout_latency", k, 16);
    drive(8'd0, 1'b0, 1'b1, 1'b0, 8'h0);
    drive(8'd0, 1'b0, 1'b0, 1'b1, 8'h0);

    // Flush issues immediately
    drive(8'd2, 1'b1, 1'b0, 1'b0, 8'h0);
    check("flush_valid", req_valid, 1);
    check("flush_count", req_count, 2);
    drive(8'd0, 1'b0, 1'b1, 1'b0, 8'h0);
    drive(8'd0, 1'b0, 1'b0, 1'b1, 8'h0);

    // Backpressure: steps pile up behind a held request, stall rises
    drive(8'd20, 1'b1, 1'b0, 1'b0, 8'h0);
    for (int i = 0; i < 5; i++) drive(8'd20, 1'b0, 1'b0, 1'b0, 8'h0);
    check("bp_count_held", req_count, 20);
    check("bp_stall", dut_stall, 1);
    drive(8'd0, 1'b0, 1'b1, 1'b0, 8'h0);
    drive(8'd0, 1'b0, 1'b0, 1'b1, 8'h0);
    drive(8'd0, 1'b0, 1'b0, 1'b0, 8'h0);
    check("bp_next_count", req_count, 100);
    drive(8'd0, 1'b0, 1'b1, 1'b0, 8'h0);
    drive(8'd0, 1'b0, 1'b0, 1'b1, 8'h0);

    // Fail verdict halts for good
    drive(8'd5, 1'b1, 1'b0, 1'b0, 8'h0);
    drive(8'd0, 1'b0, 1'b1, 1'b0, 8'h0);
    drive(8'd0, 1'b0, 1'b0, 1'b1, 8'h2);
    check("fail_simv", simv_result, 2);
    check("fail_stall", dut_stall, 1);
    for (int i = 0; i < 20; i++) drive(8'd9, 1'b1, 1'b1, 1'b1, 8'h0);
    check("halt_no_req", req_valid, 0);

    // Done verdict is sticky
    reset = 1'b1; drive(8'd0, 1'b0, 1'b0, 1'b0, 8'h0); reset = 1'b0;
    drive(8'd4, 1'b1, 1'b0, 1'b0, 8'h0);
    drive(8'd0, 1'b0, 1'b1, 1'b0, 8'h0);
    drive(8'd0, 1'b0, 1'b0, 1'b1, 8'h1);
    for (int i = 0; i < 5; i++) drive(8'd7, 1'b1, 1'b1, 1'b1, 8'h0);
    check("done_sticky", simv_result, 1);

    // Reset while waiting abandons the request; late verdict is ignored
    reset = 1'b1; drive(8'd0, 1'b0, 1'b0, 1'b0, 8'h0); reset = 1'b0;
    drive(8'd6, 1'b1, 1'b0, 1'b0, 8'h0);
    drive(8'd0, 1'b0, 1'b1, 1'b0, 8'h0);
    check("wait_busy", busy, 1);
    reset = 1'b1; drive(8'd0, 1'b0, 1'b0, 1'b0, 8'h0); reset = 1'b0;
    drive(8'd0, 1'b0, 1'b0, 1'b1, 8'h2);
    check("rstwait_simv", simv_result, 0);
    check("rstwait_batch", batch_count, 0);
    check("rstwait_busy", busy, 0);

    // Random traffic with passing verdicts
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 10 == 0) ? 8'($urandom % 256) : 8'($urandom % 16),
            ($urandom % 16 == 0), ($urandom % 4 != 0), ($urandom % 3 == 0), 8'h0);
    end
    for (int i = 0; i < 40; i++) drive(8'd0, 1'b0, 1'b1, 1'b1, 8'h0);
    check("sb_drained", exp_q.size(), 0);
    check("drain_idle", busy, 0);

    // Overflow on the 8-bit instance
    s_reset = 1'b0; s_step = 8'd255;
    cycle();
    check("ovf_first_valid", s_req_valid, 1);
    check("ovf_first_count", s_req_count, 255);
    cycle();
    check("ovf_not_yet", s_simv, 0);
    cycle();
    check("ovf_simv", s_simv, 2);
    check("ovf_stall", s_stall, 1);
    check("ovf_busy", s_busy, 0);
    check("ovf_req_valid", s_req_valid, 0);
    check("ovf_batches", s_batch, 0);

    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/difftest_step_batcher.md
# difftest_step_batcher

Controller that sits between the DUT's per-cycle commit count (`difftest_step`) and the software checker. It accumulates commits into batches and issues each batch to the checker through a valid/ready request followed by a response. The checker's verdict is latched as `simv_result` for the simulation endpoint. The block also throttles the DUT when too many commits are pending, so checker calls are amortised across many cycles without losing commits.

## Interface
Parameters:
- STEP_W, 8, width of per-cycle commit count input
- CNT_W, 32, width of accumulator and batch count
- BATCH_MAX, 64, accumulated commits that force a batch issue and raise stall
- TIMEOUT, 16, cycles a non-empty accumulator may wait before forced issue

Ports (reset reset, synchronous, active-high; clock clock):
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- step_in  in  STEP_W  commits retired this cycle
- flush  in  1  force issue of a non-empty accumulator
- req_valid  out  1  batch request to checker
- req_count  out  CNT_W  commits in the offered batch; stable while req_valid
- req_ready  in  1  checker accepts request
- rsp_valid  in  1  checker verdict valid
- rsp_result  in  8  verdict: 0 = pass/continue, 8'h1 = done, 8'h2 = fail, other = error
- simv_result  out  8  sticky verdict for the endpoint
- dut_stall  out  1  DUT must not commit further
- busy  out  1  a batch is outstanding (REQ or WAIT)
- batch_count  out  CNT_W  batches completed with verdict 0

## Operation
- States: ACCUM, REQ, WAIT, HALT. Reset → ACCUM. Reset values: acc=0, timer=0, req_count=0, simv_result=0, batch_count=0, all 1-bit outputs 0.
- Accumulation:
  - In ACCUM, REQ and WAIT: acc_next = acc + step_in. The add is zero-extended to CNT_W+1 bits.
  - If bit CNT_W of the sum is set: overflow. Go to HALT with simv_result=8'h2.
- Timer:
  - Increments each cycle while acc != 0 in ACCUM.
  - Clears when a batch is issued or when acc is 0.
- Issue (ACCUM only): triggered when any of these holds:
  - acc_next >= BATCH_MAX
  - acc != 0 and timer >= TIMEOUT-1
  - flush and acc_next != 0
- On issue: req_count <= acc_next, acc <= 0, timer <= 0, go to REQ. Steps arriving in the issue cycle belong to the issued batch.
- REQ: req_valid=1. On req_ready, go to WAIT. Steps arriving in REQ and WAIT accumulate into acc for the next batch.
- WAIT: on rsp_valid:
  - rsp_result==0: batch_count++, go to ACCUM.
  - Otherwise: simv_result <= rsp_result, go to HALT.
- rsp_valid outside WAIT is ignored. req_ready outside REQ is ignored.
- HALT: terminal until reset. req_valid=0, dut_stall=1, simv_result held. step_in is ignored.
- dut_stall = (state==HALT) | (acc >= BATCH_MAX). Steps arriving while stalled are still counted; none are dropped.
- busy = (state==REQ) | (state==WAIT).

## Timing
- Issue latency: a trigger in cycle N gives req_valid=1 in cycle N+1.
- Handshake: req_valid and req_count are held until req_ready is sampled high. Same-cycle ready gives a 1-cycle REQ, and the state is WAIT in the next cycle.
- Response: rsp_valid is accepted from the first WAIT cycle onward.
  - A pass returns to ACCUM in the next cycle. A pending acc may re-trigger immediately, so the minimum spacing from one req_valid rise to the next is 3 cycles.
  - A non-zero verdict is visible on simv_result in the cycle after rsp_valid.
- Simultaneous events:
  - Overflow in the same cycle as rsp_valid: overflow wins, simv_result=8'h2.
  - Flush in REQ or WAIT: ignored, not queued.
  - Threshold and timeout in the same cycle: one issue.
- Reset mid-operation returns the block to ACCUM with all state cleared. An outstanding request is abandoned, and a later rsp_valid is ignored because the state is no longer WAIT.

## Test plan
- step_in=8 for 8 cycles, req_ready=1, rsp 0 two cycles later → one request with req_count=64 one cycle after the 8th step; dut_stall stays 0; batch_count=1.
- Single step_in=3, then zeros → req_valid rises exactly TIMEOUT cycles after the step with req_count=3. flush with step_in=2 → request next cycle with req_count=2.
- Hold req_ready=0 for 5 cycles while step_in=20/cycle → req_count stays constant; dut_stall rises once acc>=64; all 100 commits appear in the next batch.
- rsp_result=8'h2 → simv_result=8'h2 the next cycle, dut_stall=1, no further req_valid under continued steps; rsp_result=8'h1 → simv_result=8'h1 sticky.
- CNT_W=8, keep req_ready=0 and drive step_in=255 → overflow forces HALT with simv_result=8'h2.
- Reset asserted in WAIT, followed by rsp_valid with result 2 → all outputs 0, simv_result stays 0, batch_count=0.
